// File: rtl/rr_arbiter32.sv
// Round-robin arbiter with per-grant watchdog.
// The search starts at the rotating pointer. A grant is held until the owner
// pulses done or the watchdog expires. At least one IDLE cycle separates any
// two grants.
module rr_arbiter32 #(
   parameter int N   = 32,
   parameter int IDW = 5,
   parameter int TMO = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [N-1:0]   req,
   input  logic           done,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           timeout
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [IDW:0]   N_W    = (IDW+1)'(N);
   localparam logic [IDW-1:0] LAST   = IDW'(N-1);
   localparam logic [15:0]    TMO_M1 = 16'(TMO-1);

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [15:0]      r_cnt;
   logic [N-1:0]     r_gnt;
   logic [IDW-1:0]   r_gnt_id;
   logic             r_gnt_valid;
   logic             r_timeout;

   state_t           w_state_next;
   logic [IDW-1:0]   w_ptr_next;
   logic [15:0]      w_cnt_next;
   logic [N-1:0]     w_gnt_next;
   logic [IDW-1:0]   w_gnt_id_next;
   logic             w_gnt_valid_next;
   logic             w_timeout_next;

   logic [2*N-1:0]   w_req_dbl;
   logic [N-1:0]     w_req_rot;
   logic [IDW-1:0]   w_off;
   logic [IDW:0]     w_sum;
   logic [IDW:0]     w_wrap;
   logic [IDW-1:0]   w_win;
   logic [IDW-1:0]   w_ptr_after;

   // Rotate the requests so that bit 0 corresponds to the pointer position.
   assign w_req_dbl = {req, req};
   assign w_req_rot = w_req_dbl[N-1:0] == '0 ? '0 : N'(w_req_dbl >> r_ptr);

   // Lowest set bit of the rotated vector is the offset of the winner from ptr.
   always_comb begin
      w_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_req_rot[i]) w_off = IDW'(i);
      end
   end

   // Undo the rotation: the winner is ptr + offset, modulo N.
   assign w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_wrap      = (w_sum >= N_W) ? (w_sum - N_W) : w_sum;
   assign w_win       = w_wrap[IDW-1:0];
   assign w_ptr_after = (r_gnt_id == LAST) ? '0 : r_gnt_id + 1'b1;

   // Next-state logic: grant from IDLE, release on done or watchdog expiry.
   always_comb begin
      w_state_next     = r_state;
      w_ptr_next       = r_ptr;
      w_cnt_next       = r_cnt;
      w_gnt_next       = r_gnt;
      w_gnt_id_next    = r_gnt_id;
      w_gnt_valid_next = r_gnt_valid;
      w_timeout_next   = 1'b0;
      case (r_state)
         IDLE: begin
            if (en && (req != '0)) begin
               w_state_next     = BUSY;
               w_gnt_next       = {{(N-1){1'b0}}, 1'b1} << w_win;
               w_gnt_id_next    = w_win;
               w_gnt_valid_next = 1'b1;
               w_cnt_next       = '0;
            end
         end
         BUSY: begin
            // done wins over a simultaneous watchdog expiry
            if (done || (r_cnt == TMO_M1)) begin
               w_state_next     = IDLE;
               w_ptr_next       = w_ptr_after;
               w_gnt_next       = '0;
               w_gnt_id_next    = '0;
               w_gnt_valid_next = 1'b0;
               w_cnt_next       = '0;
               w_timeout_next   = ~done;
            end else begin
               w_cnt_next = r_cnt + 16'd1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_gnt_id    <= '0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ptr       <= w_ptr_next;
         r_cnt       <= w_cnt_next;
         r_gnt       <= w_gnt_next;
         r_gnt_id    <= w_gnt_id_next;
         r_gnt_valid <= w_gnt_valid_next;
         r_timeout   <= w_timeout_next;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_id    = r_gnt_id;
   assign gnt_valid = r_gnt_valid;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed bench for rr_arbiter32 (N=32, TMO=4).
// Expected outputs are hand-computed for each step.
module tb_rr_arbiter32;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] req;
   logic        done;
   logic [31:0] gnt;
   logic [4:0]  gnt_id;
   logic        gnt_valid;
   logic        timeout;

   int n_tests = 0;
   int n_fail  = 0;

   rr_arbiter32 #(.N(32), .IDW(5), .TMO(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle so outputs are sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare all outputs against the expected tuple.
   task automatic chk(input string tag, input logic [31:0] eg, input logic [4:0] eid,
                      input logic ev, input logic et);
      logic [38:0] obs;
      logic [38:0] exp;
      obs = {gnt, gnt_id, gnt_valid, timeout};
      exp = {eg, eid, ev, et};
      n_tests++;
      assert (obs === exp)
         $display("[TB] %s gnt=%h id=%0d valid=%b to=%b", tag, gnt, gnt_id, gnt_valid, timeout);
      else begin
         n_fail++;
         $error("FAIL %s: observed gnt=%h id=%0d valid=%b to=%b expected gnt=%h id=%0d valid=%b to=%b",
                tag, gnt, gnt_id, gnt_valid, timeout, eg, eid, ev, et);
      end
   endtask

   task automatic chk_grant(input string tag, input int id);
      logic [31:0] one;
      one = 32'h1;
      chk(tag, one << id, 5'(id), 1'b1, 1'b0);
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, 32'h0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = '0; done = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      rst = 1'b0;

      // Basic grant, release, pointer advance
      req = 32'h0000_0005; en = 1'b1;
      tick();
      chk_grant("b_first", 0);
      done = 1'b1;
      tick();
      chk_idle("b_release");
      done = 1'b0;
      tick();
      chk_grant("b_second", 2);
      done = 1'b1;
      tick();
      chk_idle("b_release2");
      done = 1'b0;

      // Full rotation with every requester active
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 32'hFFFF_FFFF;
      for (int k = 0; k < 33; k++) begin
         tick();
         chk_grant($sformatf("rot_g%0d", k), k % 32);
         done = 1'b1;
         tick();
         chk_idle($sformatf("rot_i%0d", k));
         done = 1'b0;
      end

      // Pointer wrap from 31 to 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 32'h8000_0000;
      tick();
      chk_grant("wrap_31", 31);
      done = 1'b1;
      tick();
      chk_idle("wrap_rel");
      done = 1'b0;
      req = 32'h8000_0001;
      tick();
      chk_grant("wrap_0", 0);
      done = 1'b1;
      tick();
      chk_idle("wrap_rel2");
      done = 1'b0;

      // Watchdog expiry after 4 BUSY cycles (ptr=1, only req0 -> id 0)
      req = 32'h0000_0001;
      tick();
      chk_grant("wd_c1", 0);
      tick();
      chk_grant("wd_c2", 0);
      tick();
      chk_grant("wd_c3", 0);
      tick();
      chk_grant("wd_c4", 0);
      req = '0;
      tick();
      chk("wd_expire", 32'h0, 5'd0, 1'b0, 1'b1);
      tick();
      chk_idle("wd_pulse_end");

      // done coinciding with expiry: plain release, no timeout
      req = 32'h0000_0001;
      tick();
      chk_grant("wdd_c1", 0);
      req = '0;
      tick();
      tick();
      tick();
      chk_grant("wdd_c4", 0);
      done = 1'b1;
      tick();
      chk_idle("wdd_release");
      done = 1'b0;

      // Reset in the middle of BUSY (ptr=1, req=7 -> id 1)
      req = 32'h0000_0007;
      tick();
      chk_grant("rb_grant", 1);
      tick();
      rst = 1'b1;
      tick();
      chk_idle("rb_reset");
      rst = 1'b0;
      tick();
      chk_grant("rb_from0", 0);
      done = 1'b1;
      tick();
      chk_idle("rb_release");
      done = 1'b0;

      // en=0 blocks grants; en drop and req change during BUSY are ignored
      en = 1'b0; req = 32'h0000_000F;
      tick();
      chk_idle("en0_a");
      tick();
      chk_idle("en0_b");
      en = 1'b1;
      tick();
      chk_grant("en_grant", 1);
      en = 1'b0; req = '0;
      tick();
      chk_grant("en_hold1", 1);
      tick();
      chk_grant("en_hold2", 1);
      done = 1'b1;
      tick();
      chk_idle("en_release");

      // done in IDLE leaves the pointer alone (ptr=2)
      tick();
      chk_idle("idle_done");
      done = 1'b0; en = 1'b1; req = 32'h0000_0007;
      tick();
      chk_grant("idle_done_ptr", 2);
      done = 1'b1;
      tick();
      chk_idle("final_release");
      done = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter32.md
RR_ARBITER32 -- requirements
Module: rr_arbiter32

Interface
REQ-001 SHALL have parameter N, default 32, number of requesters.
REQ-002 SHALL have parameter IDW, default 5, grant index width (log2 N).
REQ-003 SHALL have parameter TMO, default 255, watchdog limit in cycles; legal range 1..65535.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, permits new grants when 1.
REQ-007 SHALL have port req, input, N, one request bit per requester.
REQ-008 SHALL have port done, input, 1, resource-release pulse from the current owner.
REQ-009 SHALL have port gnt, output, N, one-hot grant vector (registered).
REQ-010 SHALL have port gnt_id, output, IDW, binary index of the granted requester (registered).
REQ-011 SHALL have port gnt_valid, output, 1, high while a grant is held.
REQ-012 SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-013 SHALL implement two states: IDLE and BUSY.
REQ-014 SHALL hold an IDW-bit round-robin pointer ptr; the search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-015 SHALL, in IDLE with en=1 and req!=0, select the first set req bit in search order and enter BUSY at the next edge.
REQ-016 SHALL, on that same edge, set gnt to the winner's one-hot value, set gnt_id to the winner's index, and set gnt_valid=1; latency from req sample to gnt visible is exactly 1 cycle.
REQ-017 SHALL remain in IDLE, with all grant outputs 0, while en=0 or req=0.
REQ-018 SHALL, in BUSY, hold gnt, gnt_id and gnt_valid constant, ignoring req changes (including the owner dropping its req) and ignoring en.
REQ-019 SHALL, in BUSY with done=1, return to IDLE at the next edge and clear gnt, gnt_id and gnt_valid.
REQ-020 SHALL, on that release edge, set ptr to gnt_id+1, wrapping from N-1 to 0.
REQ-021 SHALL keep at least one IDLE cycle between consecutive grants; back-to-back grant cycles are therefore never produced.
REQ-022 SHALL run a watchdog counter in BUSY: cleared on entry to BUSY, incremented once per BUSY cycle without done.
REQ-023 SHALL, when the counter reaches TMO-1 with done=0, release exactly as in REQ-019/REQ-020 and pulse timeout=1 for one cycle, aligned with gnt_valid falling.
REQ-024 SHALL give done priority when done and watchdog expiry occur in the same cycle: normal release, timeout stays 0.
REQ-025 SHALL ignore done while in IDLE: no state, ptr or output change.
REQ-026 SHALL guarantee gnt is zero or exactly one-hot at all times, with gnt[gnt_id]=1 whenever gnt_valid=1.
REQ-027 SHALL grant every continuously requesting requester within N grants (starvation-free).

Reset
REQ-028 SHALL, with rst=1 at a clock edge, force IDLE, ptr=0, counter=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
REQ-029 SHALL let rst override all other inputs, including a rst asserted mid-BUSY: the grant is dropped at that edge, the ptr update is skipped, and no timeout pulse is produced.
REQ-030 SHALL, after rst deasserts, accept arbitration on the first edge.

Verification
REQ-031 SHALL verify: after reset, req=32'h0000_0005, en=1 -> next cycle gnt=32'h1, gnt_id=0; done pulse -> release, ptr=1; next grant gnt_id=2.
REQ-032 SHALL verify: req=32'hFFFF_FFFF held, done after every grant -> gnt_id sequence 0,1,2,...,31,0 with one IDLE cycle between grants.
REQ-033 SHALL verify: grant to id 31, then done -> ptr wraps to 0; with req=32'h8000_0001, next gnt_id=0.
REQ-034 SHALL verify: TMO=4, grant held without done -> gnt_valid falls after 4 BUSY cycles with timeout=1 for one cycle; with done in the 4th cycle, timeout stays 0.
REQ-035 SHALL verify: rst=1 in the middle of BUSY -> all outputs 0 at that edge, and the next grant starts its search from id 0.
REQ-036 SHALL verify: en=0 with req!=0 -> no grant; en toggled to 0 during BUSY -> grant held until done.
